// File: rtl/fu_br_multi.sv
// fu_br_multi: multi-lane Alpha branch resolution with oldest-mispredict recovery
// and a two-stage writeback pipeline that is squashed by branch mask.
module fu_br_multi #(
    parameter int N_CH      = 2,
    parameter int XLEN      = 64,
    parameter int BR_MASK_W = 5,
    parameter int PRF_IDX_W = 6,
    parameter int ROB_IDX_W = 5,
    parameter logic [PRF_IDX_W-1:0] ZERO_REG = '0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_CH-1:0]                 start_i,
    input  logic [N_CH*32-1:0]              inst_i,
    input  logic [N_CH*XLEN-1:0]            npc_i,
    input  logic [N_CH*XLEN-1:0]            opa_i,
    input  logic [N_CH*XLEN-1:0]            opb_i,
    input  logic [N_CH*PRF_IDX_W-1:0]       dest_tag_i,
    input  logic [N_CH*(ROB_IDX_W+1)-1:0]   rob_idx_i,
    input  logic [N_CH*BR_MASK_W-1:0]       br_mask_i,
    input  logic [N_CH*BR_MASK_W-1:0]       br_mask_1hot_i,
    input  logic [N_CH-1:0]                 pre_taken_i,
    input  logic [N_CH*XLEN-1:0]            pre_target_i,
    input  logic [ROB_IDX_W:0]              rob_head_i,
    input  logic                            rob_br_recovery_i,
    input  logic [BR_MASK_W-1:0]            rob_br_tag_fix_i,
    output logic                            br_wrong_o,
    output logic [BR_MASK_W-1:0]            br_recovery_mask_1hot_o,
    output logic [XLEN-1:0]                 br_recovery_target_o,
    output logic [ROB_IDX_W:0]              br_recovery_rob_idx_o,
    output logic [N_CH-1:0]                 br_right_o,
    output logic [N_CH*BR_MASK_W-1:0]       br_right_mask_1hot_o,
    output logic [N_CH-1:0]                 bp_valid_o,
    output logic [N_CH-1:0]                 bp_taken_o,
    output logic [N_CH-1:0]                 done_o,
    output logic [N_CH-1:0]                 br_wr_en_o,
    output logic [N_CH*PRF_IDX_W-1:0]       dest_tag_o,
    output logic [N_CH*(ROB_IDX_W+1)-1:0]   rob_idx_o,
    output logic [N_CH*BR_MASK_W-1:0]       br_mask_o,
    output logic [N_CH*XLEN-1:0]            br_pc_o
);
    localparam int RW = ROB_IDX_W + 1;

    typedef struct packed {
        logic                 mis;
        logic                 taken;
        logic                 cond;
        logic                 wr_en;
        logic [XLEN-1:0]      target;
        logic [XLEN-1:0]      npc;
        logic [PRF_IDX_W-1:0] dest;
        logic [RW-1:0]        rob;
        logic [BR_MASK_W-1:0] mask;
        logic [BR_MASK_W-1:0] hot;
    } s1_t;

    typedef struct packed {
        logic                 wr_en;
        logic [XLEN-1:0]      npc;
        logic [PRF_IDX_W-1:0] dest;
        logic [RW-1:0]        rob;
        logic [BR_MASK_W-1:0] mask;
        logic [BR_MASK_W-1:0] hot;
    } s2_t;

    s1_t [N_CH-1:0]       s1_d, s1_q;
    s2_t [N_CH-1:0]       s2_d, s2_q;
    logic [N_CH-1:0]      v1_d, v1_q, v2_q, alive, win_oh, keep, done;
    logic                 wrong_q, found;
    logic [RW-1:0]        age [N_CH];
    logic [RW-1:0]        best;
    logic [BR_MASK_W-1:0] win_hot, right_tags;

    for (genvar g = 0; g < N_CH; g++) begin : g_lane
        logic [31:0]     inst;
        logic [XLEN-1:0] npc, opa, opb, disp, target;
        logic            jmp, uncond, cond, c, taken;
        assign inst   = inst_i[g*32 +: 32];
        assign npc    = npc_i[g*XLEN +: XLEN];
        assign opa    = opa_i[g*XLEN +: XLEN];
        assign opb    = opb_i[g*XLEN +: XLEN];
        assign jmp    = inst[31:29] == 3'b011;
        assign uncond = inst[31:26] == 6'h30 || inst[31:26] == 6'h34;
        assign cond   = inst[31:30] == 2'b11 && !uncond;
        // cond[1:0] picks lsb==0 / ==0 / <0 / <=0, cond[2] inverts
        assign c      = inst[28] ^ (inst[27] ? (opa[XLEN-1] | (inst[26] & ~|opa))
                                             : (inst[26] ? ~|opa : ~opa[0]));
        assign taken  = jmp | uncond | (cond & c);
        assign disp   = {{(XLEN-23){inst[20]}}, inst[20:0], 2'b00};
        assign target = jmp ? {opb[XLEN-1:2], 2'b00} : taken ? npc + disp : npc;
        assign s1_d[g] = '{
            mis:    (taken != pre_taken_i[g]) || (target != pre_target_i[g*XLEN +: XLEN]),
            taken:  taken,
            cond:   cond,
            wr_en:  (jmp | uncond) && dest_tag_i[g*PRF_IDX_W +: PRF_IDX_W] != ZERO_REG,
            target: target,
            npc:    npc,
            dest:   dest_tag_i[g*PRF_IDX_W +: PRF_IDX_W],
            rob:    rob_idx_i[g*RW +: RW],
            mask:   br_mask_i[g*BR_MASK_W +: BR_MASK_W],
            hot:    br_mask_1hot_i[g*BR_MASK_W +: BR_MASK_W]
        };
        assign v1_d[g]  = start_i[g] & ~(rob_br_recovery_i &
                          |(br_mask_i[g*BR_MASK_W +: BR_MASK_W] & rob_br_tag_fix_i));
        // the cycle after our own recovery, everything in S1 is younger wrong-path work
        assign alive[g] = v1_q[g] & ~wrong_q & ~(rob_br_recovery_i & |(s1_q[g].mask & rob_br_tag_fix_i)
                          & (s1_q[g].hot != rob_br_tag_fix_i));
        assign age[g]   = s1_q[g].rob - rob_head_i;
        assign br_right_o[g] = alive[g] & ~s1_q[g].mis & ~(found & |(s1_q[g].mask & win_hot));
        assign keep[g]  = br_right_o[g] | win_oh[g];
        assign br_right_mask_1hot_o[g*BR_MASK_W +: BR_MASK_W] = br_right_o[g] ? s1_q[g].hot : '0;
        assign bp_valid_o[g] = keep[g] & s1_q[g].cond;
        assign bp_taken_o[g] = bp_valid_o[g] & s1_q[g].taken;
        assign s2_d[g] = '{
            wr_en: s1_q[g].wr_en,
            npc:   s1_q[g].npc,
            dest:  s1_q[g].dest,
            rob:   s1_q[g].rob,
            mask:  s1_q[g].mask & ~right_tags,
            hot:   s1_q[g].hot
        };
        assign done[g] = v2_q[g] & ~(found & |(s2_q[g].mask & win_hot))
                         & ~(rob_br_recovery_i & |(s2_q[g].mask & rob_br_tag_fix_i)
                         & (s2_q[g].hot != rob_br_tag_fix_i));
        assign done_o[g]     = done[g];
        assign br_wr_en_o[g] = done[g] & s2_q[g].wr_en;
        assign dest_tag_o[g*PRF_IDX_W +: PRF_IDX_W] = done[g] ? s2_q[g].dest : '0;
        assign rob_idx_o[g*RW +: RW]                = done[g] ? s2_q[g].rob : '0;
        assign br_mask_o[g*BR_MASK_W +: BR_MASK_W]  = done[g] ? s2_q[g].mask & ~right_tags : '0;
        assign br_pc_o[g*XLEN +: XLEN]              = done[g] ? s2_q[g].npc : '0;
    end

    always_comb begin
        found  = 1'b0;
        win_oh = '0;
        best   = '0;
        for (int i = 0; i < N_CH; i++)
            if (alive[i] && s1_q[i].mis && (!found || age[i] < best)) begin
                found     = 1'b1;
                best      = age[i];
                win_oh    = '0;
                win_oh[i] = 1'b1;
            end
    end

    always_comb begin
        win_hot               = '0;
        br_recovery_target_o  = '0;
        br_recovery_rob_idx_o = '0;
        for (int i = 0; i < N_CH; i++)
            if (win_oh[i]) begin
                win_hot               = s1_q[i].hot;
                br_recovery_target_o  = s1_q[i].target;
                br_recovery_rob_idx_o = s1_q[i].rob;
            end
    end

    always_comb begin
        right_tags = '0;
        for (int i = 0; i < N_CH; i++)
            right_tags = right_tags | (br_right_o[i] ? s1_q[i].hot : '0);
    end

    assign br_wrong_o              = found;
    assign br_recovery_mask_1hot_o = win_hot;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= '0;
            v2_q    <= '0;
            wrong_q <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= keep;
            wrong_q <= found;
        end
        s1_q <= s1_d;
        s2_q <= s2_d;
    end
endmodule
